// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional feature macro used by this slice: SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder_b.sv
// Single-bit full adder cell sequenced by serial_adder_ctrl.
module full_adder_b (
   input  logic a,
   input  logic b,
   input  logic c0,
   output logic s,
   output logic c
);

   // Sum and carry of one bit position.
   always_comb begin
      s = a ^ b ^ c0;
      c = (a & b) | (c0 & (a ^ b));
   end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands load in parallel on start, shift LSB-first
// through one full adder with a registered carry, and the result is presented in
// parallel with a one-cycle done strobe.
// Defining SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow flag (ovf).
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   // Holds the WIDTH-1 low result bits; the MSB comes straight from the adder
   // on the final shift, so no bit of this register is ever thrown away.
   logic [WIDTH-2:0] ps;
   logic [WIDTH-2:0] ps_shift;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;
`ifdef SERIAL_ADDER_OVF_EN
   logic             a_msb;
   logic             b_msb;
`endif

   full_adder_b u_fa (
      .a  (sa[0]),
      .b  (sb[0]),
      .c0 (carry),
      .s  (fa_s),
      .c  (fa_c)
   );

   // Next partial sum: new bit enters at the top, older bits move toward bit 0.
   always_comb begin
      ps_shift           = '0;
      ps_shift[WIDTH-2]  = fa_s;
      for (int i = 0; i < WIDTH - 2; i++) begin
         ps_shift[i] = ps[i + 1];
      end
   end

   // Control FSM plus datapath registers; outputs are registered so busy/done are glitch-free.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         ps    <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  carry <= cin;
                  ps    <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
`endif
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               carry <= fa_c;
               ps    <= ps_shift;
               if (cnt == LAST) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  sum   <= {fa_s, ps};
                  cout  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf   <= (a_msb == b_msb) && (fa_s != a_msb);
`endif
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl against an arithmetic reference model.
// Build with SERIAL_ADDER_OVF_EN defined to also check the overflow flag.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int tests_run;
   int tests_failed;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
      .cout  (cout),
      .ovf   (ovf)
`else
      .cout  (cout)
`endif
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Reference: exact unsigned sum of both operands and the carry-in.
   function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
   endfunction

   // Reference: signed overflow when equal-sign operands give a differently-signed result.
   function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      logic [W:0] r;
      r = model_add(x, y, ci);
      return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
   endfunction

   // Drives one accepted operation from IDLE and collects what the DUT reports.
   task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_cin,
                         output int lat, output int busy_cnt, output int overlap,
                         output logic [W-1:0] r_sum, output logic r_cout, output logic r_ovf);
      @(negedge clk);
      a = op_a; b = op_b; cin = op_cin; start = 1'b1;
      @(posedge clk);
      lat = -1; busy_cnt = 0; overlap = 0;
      r_sum = '0; r_cout = 1'b0; r_ovf = 1'b0;
      for (int i = 1; i <= W + 6; i++) begin
         @(negedge clk);
         start = 1'b0;
         a = $urandom; b = $urandom; cin = $urandom;
         if (busy) busy_cnt++;
         if (busy && done) overlap++;
         if (done) begin
            lat = i;
            r_sum = sum;
            r_cout = cout;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf = ovf;
`endif
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({busy, done, sum, cout} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: busy=%b done=%b sum=%h cout=%b, expected all 0", busy, done, sum, cout);
      end
`ifdef SERIAL_ADDER_OVF_EN
      tests_run++;
      if (ovf !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_ovf: got %b, expected 0", ovf);
      end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [W-1:0] va [3] = '{8'h00, 8'hFF, 8'h7F};
      logic [W-1:0] vb [3] = '{8'h00, 8'h01, 8'h01};
      int lat, bc, ov;
      logic [W-1:0] rs;
      logic rc, ro;
      logic [W:0] exp;
      for (int k = 0; k < 3; k++) begin
         run_op(va[k], vb[k], 1'b0, lat, bc, ov, rs, rc, ro);
         exp = model_add(va[k], vb[k], 1'b0);
         tests_run++;
         if (lat !== W + 1) begin
            tests_failed++;
            $display("[TB] FAIL directed_latency[%0d]: got %0d, expected %0d", k, lat, W + 1);
         end
         tests_run++;
         if (bc !== W || ov !== 0) begin
            tests_failed++;
            $display("[TB] FAIL directed_busy[%0d]: busy cycles %0d overlap %0d, expected %0d and 0", k, bc, ov, W);
         end
         tests_run++;
         if ({rc, rs} !== exp) begin
            tests_failed++;
            $display("[TB] FAIL directed_result[%0d]: got %b/%h, expected %b/%h", k, rc, rs, exp[W], exp[W-1:0]);
         end
`ifdef SERIAL_ADDER_OVF_EN
         tests_run++;
         if (ro !== model_ovf(va[k], vb[k], 1'b0)) begin
            tests_failed++;
            $display("[TB] FAIL directed_ovf[%0d]: got %b, expected %b", k, ro, model_ovf(va[k], vb[k], 1'b0));
         end
`endif
         tests_run++;
         if (done !== 1'b0 || {cout, sum} !== exp) begin
            tests_failed++;
            $display("[TB] FAIL directed_hold[%0d]: done=%b result %b/%h, expected 0 and %b/%h", k, done, cout, sum, exp[W], exp[W-1:0]);
         end
      end
   endtask

   task automatic test_ignore_start();
      int done_cnt = 0;
      int hold_err = 0;
      int done_at = -1;
      logic [W-1:0] first_sum = '1;
      logic first_cout = 1'b0;
      @(negedge clk);
      a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 2 * W + 6; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 3) begin
            a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
         end
         if (done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = c; first_sum = sum; first_cout = cout;
            end
         end
         if (done_at >= 0 && {cout, sum} !== {1'b1, 8'h00}) hold_err++;
      end
      tests_run++;
      if (done_cnt !== 1 || done_at !== W + 1) begin
         tests_failed++;
         $display("[TB] FAIL ignore_start_strobe: %0d strobes first at %0d, expected 1 at %0d", done_cnt, done_at, W + 1);
      end
      tests_run++;
      if ({first_cout, first_sum} !== model_add(8'hA5, 8'h5A, 1'b1)) begin
         tests_failed++;
         $display("[TB] FAIL ignore_start_result: got %b/%h, expected 1/00", first_cout, first_sum);
      end
      tests_run++;
      if (hold_err !== 0) begin
         tests_failed++;
         $display("[TB] FAIL ignore_start_hold: %0d cycles with result changed, expected 0", hold_err);
      end
   endtask

   task automatic test_reset_mid_shift();
      int lat, bc, ov, late_done;
      logic [W-1:0] rs;
      logic rc, ro;
      run_op(8'h7F, 8'h01, 1'b0, lat, bc, ov, rs, rc, ro);
      @(negedge clk);
      a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({busy, done, sum, cout} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL midshift_reset: busy=%b done=%b sum=%h cout=%b, expected all 0", busy, done, sum, cout);
      end
      rst_n = 1'b1;
      late_done = 0;
      for (int c = 0; c < W + 4; c++) begin
         @(negedge clk);
         if (done || busy) late_done++;
      end
      tests_run++;
      if (late_done !== 0) begin
         tests_failed++;
         $display("[TB] FAIL midshift_no_done: %0d cycles with busy/done, expected 0", late_done);
      end
      run_op(8'h3C, 8'h0F, 1'b0, lat, bc, ov, rs, rc, ro);
      tests_run++;
      if ({rc, rs} !== model_add(8'h3C, 8'h0F, 1'b0) || lat !== W + 1) begin
         tests_failed++;
         $display("[TB] FAIL midshift_rerun: got %b/%h lat %0d, expected 0/4b lat %0d", rc, rs, lat, W + 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] oa [3] = '{8'd5, 8'd200, 8'd255};
      logic [W-1:0] ob [3] = '{8'd3, 8'd100, 8'd255};
      logic         oc [3] = '{1'b0, 1'b0, 1'b1};
      int done_cyc [$];
      logic [W:0] res [$];
      int overlap = 0;
      @(negedge clk);
      a = oa[0]; b = ob[0]; cin = oc[0]; start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 3 * (W + 2) + 2; c++) begin
         @(negedge clk);
         if (c == 1) begin a = oa[1]; b = ob[1]; cin = oc[1]; end
         if (c == W + 3) begin a = oa[2]; b = ob[2]; cin = oc[2]; end
         if (c == 2 * (W + 2) + 1) start = 1'b0;
         if (busy && done) overlap++;
         if (done) begin
            done_cyc.push_back(c);
            res.push_back({cout, sum});
         end
      end
      tests_run++;
      if (done_cyc.size() !== 3 || overlap !== 0) begin
         tests_failed++;
         $display("[TB] FAIL b2b_count: %0d strobes overlap %0d, expected 3 and 0", done_cyc.size(), overlap);
      end else begin
         for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (done_cyc[k] !== (W + 1) + k * (W + 2)) begin
               tests_failed++;
               $display("[TB] FAIL b2b_timing[%0d]: done at %0d, expected %0d", k, done_cyc[k], (W + 1) + k * (W + 2));
            end
            tests_run++;
            if (res[k] !== model_add(oa[k], ob[k], oc[k])) begin
               tests_failed++;
               $display("[TB] FAIL b2b_result[%0d]: got %h, expected %h", k, res[k], model_add(oa[k], ob[k], oc[k]));
            end
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      int lat, bc, ov;
      logic [W-1:0] rs, xa, xb;
      logic rc, ro, xc;
      for (int n = 0; n < 20; n++) begin
         xa = $urandom; xb = $urandom; xc = $urandom;
         run_op(xa, xb, xc, lat, bc, ov, rs, rc, ro);
         tests_run++;
         if ({rc, rs} !== model_add(xa, xb, xc) || lat !== W + 1 || bc !== W || ov !== 0) begin
            tests_failed++;
            $display("[TB] FAIL random[%0d] %h+%h+%b: got %b/%h lat %0d busy %0d, expected %h lat %0d busy %0d",
                     n, xa, xb, xc, rc, rs, lat, bc, model_add(xa, xb, xc), W + 1, W);
         end
`ifdef SERIAL_ADDER_OVF_EN
         tests_run++;
         if (ro !== model_ovf(xa, xb, xc)) begin
            tests_failed++;
            $display("[TB] FAIL random_ovf[%0d]: got %b, expected %b", n, ro, model_ovf(xa, xb, xc));
         end
`endif
      end
   endtask

   // Runs every scenario in order, then reports.
   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_mid_shift();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
